// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared state encoding and light codes for the crossing controller
package controller_pkg;

    typedef enum logic [2:0] {
        HG = 3'd0,
        HY = 3'd1,
        AR = 3'd2,
        LG = 3'd3,
        LY = 3'd4
    } state_t;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sensor_sync.sv
// rtl/sensor_sync.sv - two-flop synchronizer for the asynchronous local-road sensor
module sensor_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    // Two back-to-back flops; both clear to "no vehicle" on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/controller.sv
// rtl/controller.sv - highway/local-road traffic-light Moore FSM; SENSOR_SYNC_EN adds a 2-flop sensor synchronizer
module controller
    import controller_pkg::*;
#(
    parameter int HG_MIN_CYCLES = 4,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 2,
    parameter int LG_MAX_CYCLES = 8
) (
    output logic [1:0] H,
    output logic [1:0] L,
    input  logic       SENSOR,
    input  logic       RST,
    input  logic       CLK
);

    localparam int CNT_MAX = max2(max2(HG_MIN_CYCLES, YELLOW_CYCLES),
                                  max2(ALLRED_CYCLES, LG_MAX_CYCLES));
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);
    localparam logic [CW-1:0] HG_LAST    = CW'(HG_MIN_CYCLES - 1);
    localparam logic [CW-1:0] YEL_LAST   = CW'(YELLOW_CYCLES - 1);
    localparam logic [CW-1:0] AR_LAST    = CW'(ALLRED_CYCLES - 1);
    localparam logic [CW-1:0] LG_LAST    = CW'(LG_MAX_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            s;

`ifdef SENSOR_SYNC_EN
    sensor_sync u_sensor_sync (
        .clk  (CLK),
        .rst  (RST),
        .din  (SENSOR),
        .dout (s)
    );
`else
    assign s = SENSOR;
`endif

    // State register and phase counter: counter restarts on every state change, saturates otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= HG;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != CNT_SAT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next-state decision; unknown encodings fall back to highway green.
    always_comb begin
        state_nxt = HG;
        case (state)
            HG:      state_nxt = (s && (cnt >= HG_LAST)) ? HY : HG;
            HY:      state_nxt = (cnt == YEL_LAST) ? AR : HY;
            AR:      state_nxt = (cnt == AR_LAST) ? LG : AR;
            LG:      state_nxt = (!s || (cnt == LG_LAST)) ? LY : LG;
            LY:      state_nxt = (cnt == YEL_LAST) ? HG : LY;
            default: state_nxt = HG;
        endcase
    end

    // Light decode from the state register only; illegal states show all red.
    always_comb begin
        H = RED;
        L = RED;
        case (state)
            HG:      H = GREEN;
            HY:      H = YELLOW;
            LG:      L = GREEN;
            LY:      L = YELLOW;
            default: begin
                H = RED;
                L = RED;
            end
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - directed self-checking bench for the crossing controller
module tb_controller;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;

    logic [1:0] h;
    logic [1:0] l;
    logic       sensor;
    logic       rst;
    logic       clk;

    int errors = 0;
    int checks = 0;

    controller dut (
        .H      (h),
        .L      (l),
        .SENSOR (sensor),
        .RST    (rst),
        .CLK    (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety invariant on every cycle: never two non-red heads, never code 11.
    always @(negedge clk) begin
        checks++;
        assert ((h === R || l === R) && h !== 2'b11 && l !== 2'b11 && !$isunknown({h, l}))
        else begin
            errors++;
            $error("FAIL invariant h=%b l=%b required one RED and no 11/X", h, l);
        end
    end

    task automatic check_lights(input logic [1:0] eh, input logic [1:0] el, input string tag);
        checks++;
        assert (h === eh && l === el)
        else begin
            errors++;
            $error("FAIL %s h=%b l=%b required h=%b l=%b", tag, h, l, eh, el);
        end
    endtask

    // Advance n edges, checking the lights 1 ns after each edge.
    task automatic expect_seq(input logic [1:0] eh, input logic [1:0] el, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_lights(eh, el, tag);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_lights(G, R, "reset_state");
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        sensor = 1'b0;

        // Idle: no vehicle keeps highway green.
        do_reset();
        expect_seq(G, R, 50, "idle_hg");

        // Vehicle arrives at cycle 10 after reset and stays: LG runs to its maximum.
        do_reset();
        expect_seq(G, R, 10, "pre_req_hg");
        sensor = 1'b1;
        expect_seq(Y, R, 3, "held_hy");
        expect_seq(R, R, 2, "held_ar");
        expect_seq(R, G, 8, "held_lg_max");
        expect_seq(R, Y, 3, "held_ly");
        // Still waiting: highway gets its minimum green before the next service.
        expect_seq(G, R, 4, "held_hg_min");
        expect_seq(Y, R, 1, "held_reserve_hy");
        sensor = 1'b0;

        // Request right after reset: min green of 4 cycles enforced.
        do_reset();
        sensor = 1'b1;
        expect_seq(G, R, 3, "min_green_hg");
        expect_seq(Y, R, 3, "min_green_hy");
        expect_seq(R, R, 2, "min_green_ar");
        expect_seq(R, G, 2, "pre_abort_lg");
        // Reset mid-LG aborts straight to highway green.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_lights(G, R, "abort_lg_reset");
        rst    = 1'b0;
        sensor = 1'b0;
        expect_seq(G, R, 3, "post_abort_hg");

        // Vehicle present for 10 edges, then leaves: LG ends early.
        do_reset();
        expect_seq(G, R, 5, "early_pre_hg");
        sensor = 1'b1;
        expect_seq(Y, R, 3, "early_hy");
        expect_seq(R, R, 2, "early_ar");
        expect_seq(R, G, 5, "early_lg");
        sensor = 1'b0;
        expect_seq(R, Y, 3, "early_ly");
        expect_seq(G, R, 3, "early_back_hg");

        // Single-cycle pulse once min green is met: full sequence, LG for one cycle.
        do_reset();
        expect_seq(G, R, 5, "pulse_pre_hg");
        sensor = 1'b1;
        expect_seq(Y, R, 1, "pulse_hy_first");
        sensor = 1'b0;
        expect_seq(Y, R, 2, "pulse_hy_rest");
        expect_seq(R, R, 2, "pulse_ar");
        expect_seq(R, G, 1, "pulse_lg_one");
        expect_seq(R, Y, 3, "pulse_ly");
        expect_seq(G, R, 6, "pulse_back_hg");

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
